// File: rtl/horner_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : horner_sequencer
//  Purpose  : Control sequencer for a Horner-scheme polynomial evaluator.
//             It accepts a job of (segment, term count) from the operand FIFO.
//             For each job it clears the datapath accumulator and reads X.
//             It then walks the coefficient ROM from the highest index down.
//             Each step issues one multiply and one add.
//             At the end it loads the result register.
//             done_o follows each load_result_o by DONE_DELAY cycles.
//
//  Parameters
//    ADDR_LINES  term-index width (max terms per job = 2^ADDR_LINES-1)
//    NUM_SEG     number of coefficient banks
//    DONE_DELAY  cycles from load_result_o to done_o (1..8)
//    TIMEOUT     wait-state limit (only with HORNER_SEQ_TIMEOUT_EN)
//
//  Ports
//    clk_i, rst_i            clock, synchronous active-high reset
//    in_valid_i/in_ready_o   job handshake (seg_i, terms_i sampled on accept)
//    dp_clear_o              accumulator clear pulse
//    rd_signal_o             FIFO read enable (operand X)
//    rd_coeff_o/coeff_addr_o ROM read enable and {segment, index} address
//    mul_valid_o/mul_done_i  multiplier start / completion
//    add_valid_o/add_done_i  adder start / completion
//    load_result_o           output register load
//    done_o                  job-complete pulse
//    busy_o                  high in every state except IDLE
//    err_o                   wait-state timeout pulse (optional)
//
//  Configuration macro
//    HORNER_SEQ_TIMEOUT_EN : adds err_o and a timeout counter on the wait
//                            states; without it the wait states are unbounded.
//
//  Revision : 1.0  initial release
// ============================================================================
module horner_sequencer #(
    parameter int ADDR_LINES = 5,
    parameter int NUM_SEG    = 4,
    parameter int DONE_DELAY = 5,
`ifdef HORNER_SEQ_TIMEOUT_EN
    parameter int TIMEOUT    = 64,
`endif
    localparam int SEG_W     = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [SEG_W-1:0]            seg_i,
    input  logic [ADDR_LINES-1:0]       terms_i,
    output logic                        dp_clear_o,
    output logic                        rd_signal_o,
    output logic                        rd_coeff_o,
    output logic [SEG_W+ADDR_LINES-1:0] coeff_addr_o,
    output logic                        mul_valid_o,
    output logic                        add_valid_o,
    input  logic                        mul_done_i,
    input  logic                        add_done_i,
    output logic                        load_result_o,
    output logic                        done_o,
    output logic                        busy_o
`ifdef HORNER_SEQ_TIMEOUT_EN
    ,
    output logic                        err_o
`endif
);

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_CLEAR      = 4'd1;
    localparam logic [3:0] ST_LOAD_X     = 4'd2;
    localparam logic [3:0] ST_LOAD_COEFF = 4'd3;
    localparam logic [3:0] ST_MUL        = 4'd4;
    localparam logic [3:0] ST_WAIT_MUL   = 4'd5;
    localparam logic [3:0] ST_ADD        = 4'd6;
    localparam logic [3:0] ST_WAIT_ADD   = 4'd7;
    localparam logic [3:0] ST_CHECK      = 4'd8;
    localparam logic [3:0] ST_STORE      = 4'd9;

    localparam logic [ADDR_LINES-1:0] C_ONE = ADDR_LINES'(1);

    logic [3:0]            state_q, state_d;
    logic [ADDR_LINES-1:0] count_q, count_d;
    logic [SEG_W-1:0]      seg_q,   seg_d;
    logic [ADDR_LINES-1:0] terms_q, terms_d;
    logic [DONE_DELAY-1:0] done_pipe_q, done_pipe_d;

    logic w_accept;
    logic w_timeout;

    // Ready is only offered in IDLE and STORE; STORE accepting a job chains
    // straight into CLEAR so back-to-back jobs lose no cycle.
    assign w_accept = in_valid_i &&
                      ((state_q == ST_IDLE) || (state_q == ST_STORE));

    // ------------------------------------------------------------------
    // Optional wait-state timeout
    // ------------------------------------------------------------------
`ifdef HORNER_SEQ_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             w_in_wait;
    logic             w_wait_done;

    assign w_in_wait   = (state_q == ST_WAIT_MUL) || (state_q == ST_WAIT_ADD);
    assign w_wait_done = ((state_q == ST_WAIT_MUL) && mul_done_i) ||
                         ((state_q == ST_WAIT_ADD) && add_done_i);

    // tmo_q holds (cycles already spent in the wait state); the TIMEOUT-th
    // wait cycle without a completion is the expiry cycle.
    assign w_timeout = w_in_wait && !w_wait_done &&
                       (tmo_q == TMO_W'(TIMEOUT - 1));

    always_comb begin
        tmo_d = '0;
        if (w_in_wait && !w_wait_done && !w_timeout) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign err_o = w_timeout && !rst_i;
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            seg_q       <= '0;
            terms_q     <= '0;
            done_pipe_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            seg_q       <= seg_d;
            terms_q     <= terms_d;
            done_pipe_q <= done_pipe_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        seg_d   = seg_q;
        terms_d = terms_q;

        case (state_q)
            ST_IDLE, ST_STORE: begin
                if (w_accept) begin
                    state_d = ST_CLEAR;
                    count_d = '0;
                    seg_d   = seg_i;
                    terms_d = terms_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR:      state_d = ST_LOAD_X;
            // A zero-term job evaluates to the cleared accumulator.
            ST_LOAD_X:     state_d = (terms_q == '0) ? ST_STORE : ST_LOAD_COEFF;
            ST_LOAD_COEFF: state_d = ST_MUL;
            ST_MUL:        state_d = ST_WAIT_MUL;
            ST_WAIT_MUL: begin
                if (mul_done_i) begin
                    state_d = ST_ADD;
                end else if (w_timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD:        state_d = ST_WAIT_ADD;
            ST_WAIT_ADD: begin
                if (add_done_i) begin
                    state_d = ST_CHECK;
                end else if (w_timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                // terms_q >= 1 here, so terms_q-1 cannot wrap.
                if (count_q < (terms_q - C_ONE)) begin
                    count_d = count_q + C_ONE;
                    state_d = ST_LOAD_COEFF;
                end else begin
                    state_d = ST_STORE;
                end
            end
            default:       state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (outputs forced quiet while reset is held)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready_o    = 1'b0;
        busy_o        = 1'b0;
        dp_clear_o    = 1'b0;
        rd_signal_o   = 1'b0;
        rd_coeff_o    = 1'b0;
        mul_valid_o   = 1'b0;
        add_valid_o   = 1'b0;
        load_result_o = 1'b0;

        if (rst_i) begin
            in_ready_o = 1'b1;
        end else begin
            busy_o = (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE:       in_ready_o  = 1'b1;
                ST_CLEAR:      dp_clear_o  = 1'b1;
                ST_LOAD_X:     rd_signal_o = 1'b1;
                ST_LOAD_COEFF: rd_coeff_o  = 1'b1;
                ST_MUL:        mul_valid_o = 1'b1;
                ST_ADD:        add_valid_o = 1'b1;
                ST_STORE: begin
                    in_ready_o    = 1'b1;
                    load_result_o = 1'b1;
                end
                default: ;
            endcase
        end

        // Horner order: highest coefficient first. In IDLE the address
        // previews the first coefficient of the job being offered.
        if (state_q == ST_IDLE) begin
            coeff_addr_o = {seg_i, terms_i - C_ONE};
        end else begin
            coeff_addr_o = {seg_q, terms_q - C_ONE - count_q};
        end
    end

    // ------------------------------------------------------------------
    // done_o delay line: a shift register keeps every pulse of
    // back-to-back jobs independent.
    // ------------------------------------------------------------------
    generate
        if (DONE_DELAY == 1) begin : g_done_single
            always_comb done_pipe_d = load_result_o;
        end else begin : g_done_shift
            always_comb done_pipe_d = {done_pipe_q[DONE_DELAY-2:0], load_result_o};
        end
    endgenerate

    assign done_o = done_pipe_q[DONE_DELAY-1] && !rst_i;

endmodule
`default_nettype wire

// File: tb/tb_horner_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_horner_sequencer
//  Purpose  : Self-checking bench for horner_sequencer. A datapath responder
//             answers mul/add starts after programmable latencies. Jobs push
//             their expected ROM addresses and term counts to scoreboard
//             queues; a monitor pops and compares them as the DUT acts.
//  Revision : 1.0  initial release
// ============================================================================
module tb_horner_sequencer;

    localparam int ADDR_LINES = 5;
    localparam int NUM_SEG    = 4;
    localparam int DONE_DELAY = 5;
    localparam int SEG_W      = 2;
    localparam int AW         = SEG_W + ADDR_LINES;

    logic                  clk_i;
    logic                  rst_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [SEG_W-1:0]      seg_i;
    logic [ADDR_LINES-1:0] terms_i;
    logic                  dp_clear_o;
    logic                  rd_signal_o;
    logic                  rd_coeff_o;
    logic [AW-1:0]         coeff_addr_o;
    logic                  mul_valid_o;
    logic                  add_valid_o;
    logic                  mul_done_i;
    logic                  add_done_i;
    logic                  load_result_o;
    logic                  done_o;
    logic                  busy_o;
`ifdef HORNER_SEQ_TIMEOUT_EN
    logic                  err_o;
`endif

`ifdef HORNER_SEQ_TIMEOUT_EN
    horner_sequencer #(
        .ADDR_LINES (ADDR_LINES),
        .NUM_SEG    (NUM_SEG),
        .DONE_DELAY (DONE_DELAY),
        .TIMEOUT    (16)
    ) u_dut (
`else
    horner_sequencer #(
        .ADDR_LINES (ADDR_LINES),
        .NUM_SEG    (NUM_SEG),
        .DONE_DELAY (DONE_DELAY)
    ) u_dut (
`endif
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .seg_i         (seg_i),
        .terms_i       (terms_i),
        .dp_clear_o    (dp_clear_o),
        .rd_signal_o   (rd_signal_o),
        .rd_coeff_o    (rd_coeff_o),
        .coeff_addr_o  (coeff_addr_o),
        .mul_valid_o   (mul_valid_o),
        .add_valid_o   (add_valid_o),
        .mul_done_i    (mul_done_i),
        .add_done_i    (add_done_i),
        .load_result_o (load_result_o),
        .done_o        (done_o),
        .busy_o        (busy_o)
`ifdef HORNER_SEQ_TIMEOUT_EN
        ,
        .err_o         (err_o)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Clock and cycle counter
    int cyc = 0;
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end
    initial begin
        forever begin
            @(posedge clk_i);
            cyc++;
        end
    end

    // Scoreboard
    logic [AW-1:0] addr_q[$];
    int            job_q[$];
    int            done_q[$];

    // Responder controls
    int mul_lat     = 1;
    int add_lat     = 1;
    bit stray_en    = 1'b0;
    bit withhold    = 1'b0;

    // Datapath responder: completion pulse lands in the lat-th wait cycle.
    initial begin
        int mul_cnt   = 0;
        int add_cnt   = 0;
        int stray_cnt = 0;
        mul_done_i = 1'b0;
        add_done_i = 1'b0;
        forever begin
            @(negedge clk_i);
            mul_done_i = 1'b0;
            add_done_i = 1'b0;
            if (mul_cnt > 0) begin
                mul_cnt--;
                if (mul_cnt == 0) mul_done_i = 1'b1;
            end
            if (add_cnt > 0) begin
                add_cnt--;
                if (add_cnt == 0) add_done_i = 1'b1;
            end
            if (stray_cnt > 0) begin
                stray_cnt--;
                if (stray_cnt == 0) add_done_i = 1'b1;
            end
            if (mul_valid_o && !withhold) mul_cnt = mul_lat;
            if (mul_valid_o && stray_en)  stray_cnt = 3;
            if (add_valid_o)              add_cnt = add_lat;
        end
    end

    // Monitor: per-job activity counters and scoreboard comparisons
    int n_clr = 0, n_rdx = 0, n_coef = 0, n_mul = 0, n_add = 0;
    int mul_cyc = 0, load_total = 0, done_total = 0;
    initial begin
        forever begin
            @(negedge clk_i);
            if (dp_clear_o)  n_clr++;
            if (rd_signal_o) n_rdx++;
            if (rd_coeff_o) begin
                n_coef++;
                if (addr_q.size() == 0) check_eq("coeff_unexpected", 32'd1, 32'd0);
                else check_eq("coeff_addr", 32'(coeff_addr_o), 32'(addr_q.pop_front()));
            end
            if (mul_valid_o) begin
                n_mul++;
                mul_cyc = cyc;
            end
            if (add_valid_o) begin
                n_add++;
                check_eq("mul_to_add", cyc - mul_cyc, mul_lat + 1);
            end
            if (load_result_o) begin
                load_total++;
                if (job_q.size() == 0) begin
                    check_eq("load_unexpected", 32'd1, 32'd0);
                end else begin
                    int t;
                    t = job_q.pop_front();
                    check_eq("job_mul",   n_mul,  t);
                    check_eq("job_add",   n_add,  t);
                    check_eq("job_coeff", n_coef, t);
                    check_eq("job_clear", n_clr,  1);
                    check_eq("job_readx", n_rdx,  1);
                end
                n_clr = 0; n_rdx = 0; n_coef = 0; n_mul = 0; n_add = 0;
                done_q.push_back(cyc);
            end
            if (done_o) begin
                done_total++;
                if (done_q.size() == 0) check_eq("done_unexpected", 32'd1, 32'd0);
                else check_eq("done_delay", cyc - done_q.pop_front(), DONE_DELAY);
            end
        end
    end

    // Offer one job; must be called at a falling edge.
    task automatic send_job(input int seg, input int terms, input bit keep);
        int guard = 0;
        while (!in_ready_o && guard < 500) begin
            @(negedge clk_i);
            guard++;
        end
        check_eq("ready_wait", 32'(in_ready_o), 32'd1);
        seg_i      = SEG_W'(seg);
        terms_i    = ADDR_LINES'(terms);
        in_valid_i = 1'b1;
        for (int i = 0; i < terms; i++) begin
            addr_q.push_back({seg_i, ADDR_LINES'(terms - 1 - i)});
        end
        job_q.push_back(terms);
        @(negedge clk_i);
        if (!keep) in_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((busy_o || done_q.size() != 0) && guard < 1000) begin
            @(negedge clk_i);
            guard++;
        end
        check_eq("idle_wait", 32'(busy_o), 32'd0);
    endtask

    task automatic flush_sb();
        addr_q.delete();
        job_q.delete();
        done_q.delete();
        n_clr = 0; n_rdx = 0; n_coef = 0; n_mul = 0; n_add = 0;
    endtask

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Main sequence
    initial begin
        int seen;
        int loads_before;
        int dones_before;
        rst_i      = 1'b1;
        in_valid_i = 1'b0;
        seg_i      = '0;
        terms_i    = '0;
        repeat (3) @(negedge clk_i);

        // Reset state
        check_eq("rst_ready", 32'(in_ready_o),    32'd1);
        check_eq("rst_busy",  32'(busy_o),        32'd0);
        check_eq("rst_load",  32'(load_result_o), 32'd0);
        check_eq("rst_done",  32'(done_o),        32'd0);
        check_eq("rst_clear", 32'(dp_clear_o),    32'd0);
        check_eq("rst_addr",  32'(coeff_addr_o),  32'h1F);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("idle_ready", 32'(in_ready_o), 32'd1);
        check_eq("idle_busy",  32'(busy_o),     32'd0);

        // IDLE previews {seg_i, terms_i-1}
        seg_i   = 2'd1;
        terms_i = 5'd4;
        #1;
        check_eq("idle_addr", 32'(coeff_addr_o), 32'h23);
        @(negedge clk_i);

        // seg=2, terms=3, unit latencies
        send_job(2, 3, 1'b0);
        wait_idle();

        // Three back-to-back jobs with in_valid held high
        send_job(1, 2, 1'b1);
        send_job(0, 2, 1'b1);
        send_job(3, 2, 1'b0);
        wait_idle();

        // Zero-term job, then the single- and maximum-term extremes
        send_job(0, 0, 1'b0);
        wait_idle();
        send_job(3, 1, 1'b0);
        wait_idle();
        send_job(3, 31, 1'b0);
        wait_idle();

        // Slow multiplier with a stray add completion inside WAIT_MUL
        mul_lat  = 10;
        stray_en = 1'b1;
        send_job(1, 2, 1'b0);
        wait_idle();
        stray_en = 1'b0;
        mul_lat  = 1;

        // Reset during WAIT_ADD of the second term
        add_lat = 4;
        loads_before = load_total;
        send_job(1, 3, 1'b0);
        seen = 0;
        for (int i = 0; i < 200 && seen < 2; i++) begin
            @(negedge clk_i);
            if (add_valid_o) seen++;
        end
        check_eq("reach_add2", seen, 2);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check_eq("rst_mid_busy",  32'(busy_o),     32'd0);
        check_eq("rst_mid_ready", 32'(in_ready_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        flush_sb();
        #1;
        check_eq("post_rst_busy", 32'(busy_o), 32'd0);
        dones_before = done_total;
        repeat (10) @(negedge clk_i);
        check_eq("post_rst_done", done_total, dones_before);
        check_eq("post_rst_load", load_total, loads_before);
        add_lat = 1;

`ifdef HORNER_SEQ_TIMEOUT_EN
        // Withheld multiplier completion must time out after 16 wait cycles
        begin
            int t0;
            int got_err;
            withhold = 1'b1;
            loads_before = load_total;
            send_job(2, 2, 1'b0);
            t0 = -1;
            for (int i = 0; i < 50 && t0 < 0; i++) begin
                if (mul_valid_o) t0 = cyc;
                else @(negedge clk_i);
            end
            got_err = 0;
            for (int i = 0; i < 40 && got_err == 0; i++) begin
                @(negedge clk_i);
                if (err_o) begin
                    got_err = 1;
                    check_eq("err_delay", cyc - t0, 16);
                end
            end
            check_eq("err_seen", got_err, 1);
            @(negedge clk_i);
            check_eq("tmo_idle", 32'(busy_o), 32'd0);
            flush_sb();
            repeat (DONE_DELAY + 2) @(negedge clk_i);
            check_eq("tmo_load", load_total, loads_before);
            withhold = 1'b0;
        end
`endif

        // Totals: 1 + 3 + 3 + 1 completed jobs
        check_eq("load_total", load_total, 8);
        check_eq("done_total", done_total, 8);
        check_eq("addr_left",  addr_q.size(), 0);
        check_eq("job_left",   job_q.size(),  0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
